// File: rtl/ad_line_sampler_if.sv
// Bundle for the ADC line sampler: control, raw ADC bus, runtime config, sample and status outputs.
// The master modport drives the sampler; the slave modport is the sampler itself.
interface ad_line_sampler_if #(
  parameter int DATA_W   = 12,
  parameter int CNT_W    = 16,
  parameter int VS_CNT_W = 6,
  parameter int HS_CNT_W = 10
);
  logic                enable;
  logic                vsync_redge;
  logic                hsync_redge;
  logic [DATA_W-1:0]   ad_in;
  logic [CNT_W-1:0]    delay_cfg;
  logic [CNT_W-1:0]    decim_cfg;
  logic [CNT_W-1:0]    spl_cfg;
  logic [DATA_W-1:0]   sample_data_o;
  logic                sample_valid_o;
  logic                line_done_o;
  logic                frame_done_o;
  logic                line_err_o;
  logic                frame_err_o;
  logic [VS_CNT_W-1:0] vs_cnt_o;
  logic [HS_CNT_W-1:0] hs_cnt_o;

  modport master (
    output enable, vsync_redge, hsync_redge, ad_in, delay_cfg, decim_cfg, spl_cfg,
    input  sample_data_o, sample_valid_o, line_done_o, frame_done_o, line_err_o,
           frame_err_o, vs_cnt_o, hs_cnt_o
  );
  modport slave (
    input  enable, vsync_redge, hsync_redge, ad_in, delay_cfg, decim_cfg, spl_cfg,
    output sample_data_o, sample_valid_o, line_done_o, frame_done_o, line_err_o,
           frame_err_o, vs_cnt_o, hs_cnt_o
  );
endinterface

// File: rtl/ad_line_sampler.sv
// Line-synchronous ADC capture: frame on vsync, line on hsync, per-line delay, then decimated samples.
// Config is shadowed at each line start; a line-ending hsync immediately starts the next line.
module ad_line_sampler #(
  parameter int DATA_W          = 12,
  parameter int LINES_PER_FRAME = 90,
  parameter bit BIT_REVERSE     = 1'b1,
  parameter int CNT_W           = 16,
  parameter int VS_CNT_W        = 6,
  parameter int HS_CNT_W        = 10
) (
  input  logic              clk,
  input  logic              rst,
  ad_line_sampler_if.slave  bus
);
  localparam logic [1:0] S_WAIT_VS = 2'd0;
  localparam logic [1:0] S_WAIT_HS = 2'd1;
  localparam logic [1:0] S_DELAY   = 2'd2;
  localparam logic [1:0] S_SAMPLE  = 2'd3;

  localparam logic [HS_CNT_W-1:0] LAST_LINE = HS_CNT_W'(LINES_PER_FRAME);

  logic [1:0]          state_q, state_d;
  logic [VS_CNT_W-1:0] vs_cnt_q, vs_cnt_d;
  logic [HS_CNT_W-1:0] hs_cnt_q, hs_cnt_d;
  logic [CNT_W-1:0]    delay_cnt_q, delay_cnt_d;
  logic [CNT_W-1:0]    dec_cnt_q, dec_cnt_d;
  logic [CNT_W-1:0]    samp_cnt_q, samp_cnt_d;
  logic [CNT_W-1:0]    dly_lat_q, dly_lat_d;
  logic [CNT_W-1:0]    dec_lat_q, dec_lat_d;
  logic [CNT_W-1:0]    spl_lat_q, spl_lat_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                line_done_q, line_done_d;
  logic                frame_done_q, frame_done_d;
  logic                line_err_q, line_err_d;
  logic                frame_err_q, frame_err_d;

  logic [DATA_W-1:0]   ad_ord;
  logic                resync, line_start, line_end, hs_end, take, last;

  always_comb begin
    ad_ord = bus.ad_in;
    if (BIT_REVERSE)
      for (int i = 0; i < DATA_W; i++) ad_ord[i] = bus.ad_in[DATA_W-1-i];
  end

  always_comb begin
    state_d      = state_q;
    vs_cnt_d     = vs_cnt_q;
    hs_cnt_d     = hs_cnt_q;
    delay_cnt_d  = delay_cnt_q;
    dec_cnt_d    = dec_cnt_q;
    samp_cnt_d   = samp_cnt_q;
    dly_lat_d    = dly_lat_q;
    dec_lat_d    = dec_lat_q;
    spl_lat_d    = spl_lat_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    line_done_d  = 1'b0;
    frame_done_d = 1'b0;
    line_err_d   = 1'b0;
    frame_err_d  = 1'b0;
    resync       = 1'b0;
    line_start   = 1'b0;
    line_end     = 1'b0;
    hs_end       = 1'b0;
    last         = (spl_lat_q != '0) && ((samp_cnt_q + CNT_W'(1)) == spl_lat_q);
    take         = 1'b0;

    case (state_q)
      S_WAIT_VS: begin
        if (bus.vsync_redge && bus.enable) begin
          state_d  = S_WAIT_HS;
          vs_cnt_d = vs_cnt_q + VS_CNT_W'(1);
          hs_cnt_d = '0;
        end
      end
      S_WAIT_HS: begin
        if (bus.vsync_redge)      resync     = 1'b1;
        else if (bus.hsync_redge) line_start = 1'b1;
      end
      S_DELAY: begin
        if (bus.vsync_redge) resync = 1'b1;
        else if (bus.hsync_redge) begin
          line_err_d = 1'b1;
          line_end   = 1'b1;
          hs_end     = 1'b1;
        end else if (delay_cnt_q == dly_lat_q) begin
          state_d    = S_SAMPLE;
          dec_cnt_d  = '0;
          samp_cnt_d = '0;
        end else begin
          delay_cnt_d = delay_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (bus.vsync_redge) resync = 1'b1;
        else begin
          // A same-cycle hsync suppresses the sample unless it is the line's final one.
          take      = (dec_cnt_q == '0) && (!bus.hsync_redge || last);
          dec_cnt_d = (dec_cnt_q == dec_lat_q) ? '0 : dec_cnt_q + CNT_W'(1);
          if (take) begin
            data_d     = ad_ord;
            valid_d    = 1'b1;
            samp_cnt_d = samp_cnt_q + CNT_W'(1);
          end
          if (bus.hsync_redge || (take && last)) begin
            line_end = 1'b1;
            hs_end   = bus.hsync_redge;
          end
        end
      end
    endcase

    if (resync) begin
      frame_err_d = 1'b1;
      vs_cnt_d    = vs_cnt_q + VS_CNT_W'(1);
      hs_cnt_d    = '0;
      state_d     = bus.enable ? S_WAIT_HS : S_WAIT_VS;
    end

    if (line_end) begin
      line_done_d = 1'b1;
      if (hs_cnt_q == LAST_LINE) begin
        frame_done_d = 1'b1;
        state_d      = S_WAIT_VS;
      end else if (hs_end) line_start = 1'b1;
      else                 state_d    = S_WAIT_HS;
    end

    if (line_start) begin
      hs_cnt_d    = hs_cnt_q + HS_CNT_W'(1);
      delay_cnt_d = '0;
      dly_lat_d   = bus.delay_cfg;
      dec_lat_d   = bus.decim_cfg;
      spl_lat_d   = bus.spl_cfg;
      state_d     = S_DELAY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_WAIT_VS;
      vs_cnt_q     <= '0;
      hs_cnt_q     <= '0;
      delay_cnt_q  <= '0;
      dec_cnt_q    <= '0;
      samp_cnt_q   <= '0;
      dly_lat_q    <= '0;
      dec_lat_q    <= '0;
      spl_lat_q    <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_cnt_q     <= vs_cnt_d;
      hs_cnt_q     <= hs_cnt_d;
      delay_cnt_q  <= delay_cnt_d;
      dec_cnt_q    <= dec_cnt_d;
      samp_cnt_q   <= samp_cnt_d;
      dly_lat_q    <= dly_lat_d;
      dec_lat_q    <= dec_lat_d;
      spl_lat_q    <= spl_lat_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      line_done_q  <= line_done_d;
      frame_done_q <= frame_done_d;
      line_err_q   <= line_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.sample_data_o  = data_q;
  assign bus.sample_valid_o = valid_q;
  assign bus.line_done_o    = line_done_q;
  assign bus.frame_done_o   = frame_done_q;
  assign bus.line_err_o     = line_err_q;
  assign bus.frame_err_o    = frame_err_q;
  assign bus.vs_cnt_o       = vs_cnt_q;
  assign bus.hs_cnt_o       = hs_cnt_q;
endmodule

// File: tb/tb_ad_line_sampler.sv
// Random vsync/hsync/enable/config traffic against an event-level model of frames and lines,
// plus reset checks before the run and in the middle of a sampling line.
module tb_ad_line_sampler;
  localparam int DATA_W = 12;
  localparam int LPF    = 3;
  localparam int CNT_W  = 16;
  localparam int VSW    = 6;
  localparam int HSW    = 10;
  localparam int N      = 4000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ad_line_sampler_if #(.DATA_W(DATA_W), .CNT_W(CNT_W), .VS_CNT_W(VSW), .HS_CNT_W(HSW)) bus ();

  ad_line_sampler #(
    .DATA_W(DATA_W), .LINES_PER_FRAME(LPF), .BIT_REVERSE(1'b1),
    .CNT_W(CNT_W), .VS_CNT_W(VSW), .HS_CNT_W(HSW)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // stimulus per cycle
  bit en_s[N], vs_s[N], hs_s[N];
  int ad_s[N], dly_s[N], dec_s[N], spl_s[N];
  // expected outputs after the edge of each cycle
  bit e_val[N], e_ld[N], e_fd[N], e_le[N], e_fe[N];
  int chg_vs[N], chg_hs[N], chg_dat[N];
  int e_vsc[N], e_hsc[N], e_dat[N];

  int m_where, m_t, m_s, m_line, m_vsc;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rev(int v);
    int r = 0;
    for (int i = 0; i < DATA_W; i++) if (v[i]) r |= (1 << (DATA_W-1-i));
    return r;
  endfunction

  task automatic resync(int c);
    e_fe[c]   = 1'b1;
    m_vsc     = (m_vsc + 1) % 64;
    m_line    = 0;
    chg_vs[c] = m_vsc;
    chg_hs[c] = 0;
    m_where   = en_s[c] ? 1 : 0;
    m_t       = c + 1;
  endtask

  task automatic end_line(int c, bit by_hs);
    e_ld[c] = 1'b1;
    if (m_line == LPF) begin
      e_fd[c] = 1'b1; m_where = 0; m_t = c + 1;
    end else if (by_hs) begin
      m_where = 2; m_s = c; m_t = c;
    end else begin
      m_where = 1; m_t = c + 1;
    end
  endtask

  // Walks the stimulus frame by frame and line by line; sample instants come from
  // the line start, delay and decimation period arithmetically.
  task automatic build_model();
    int d, m, l, cnt, c, off, cur;
    bit done, tk, lim;
    for (int i = 0; i < N; i++) begin
      e_val[i] = 0; e_ld[i] = 0; e_fd[i] = 0; e_le[i] = 0; e_fe[i] = 0;
      chg_vs[i] = -1; chg_hs[i] = -1; chg_dat[i] = -1;
    end
    m_where = 0; m_t = 0; m_line = 0; m_vsc = 0;
    while (m_t < N) begin
      if (m_where == 0) begin
        if (vs_s[m_t] && en_s[m_t]) begin
          m_vsc = (m_vsc + 1) % 64; m_line = 0;
          chg_vs[m_t] = m_vsc; chg_hs[m_t] = 0; m_where = 1;
        end
        m_t++;
      end else if (m_where == 1) begin
        if (vs_s[m_t])      resync(m_t);
        else if (hs_s[m_t]) begin m_where = 2; m_s = m_t; end
        else                m_t++;
      end else begin
        m_line++;
        chg_hs[m_s] = m_line;
        d = dly_s[m_s]; m = dec_s[m_s]; l = spl_s[m_s]; cnt = 0;
        done = 0;
        c = m_s + 1;
        while (!done && c < N) begin
          if (vs_s[c]) begin
            resync(c); done = 1;
          end else if (c <= m_s + d + 1) begin
            if (hs_s[c]) begin e_le[c] = 1'b1; end_line(c, 1'b1); done = 1; end
          end else begin
            off = c - (m_s + d + 2);
            tk  = (off % (m + 1)) == 0;
            lim = tk && (l != 0) && (cnt + 1 == l);
            if (hs_s[c] && !lim) tk = 0;
            if (tk) begin e_val[c] = 1'b1; chg_dat[c] = rev(ad_s[c]); cnt++; end
            if (hs_s[c] || lim) begin end_line(c, hs_s[c]); done = 1; end
          end
          c++;
        end
        if (!done) m_t = N;
      end
    end
    cur = 0;
    for (int i = 0; i < N; i++) begin if (chg_vs[i] >= 0) cur = chg_vs[i]; e_vsc[i] = cur; end
    cur = 0;
    for (int i = 0; i < N; i++) begin if (chg_hs[i] >= 0) cur = chg_hs[i]; e_hsc[i] = cur; end
    cur = 0;
    for (int i = 0; i < N; i++) begin if (chg_dat[i] >= 0) cur = chg_dat[i]; e_dat[i] = cur; end
  endtask

  task automatic chk_zero(string pfx);
    chk({pfx, "_data"},  32'(bus.sample_data_o),  0);
    chk({pfx, "_valid"}, 32'(bus.sample_valid_o), 0);
    chk({pfx, "_ld"},    32'(bus.line_done_o),    0);
    chk({pfx, "_fd"},    32'(bus.frame_done_o),   0);
    chk({pfx, "_le"},    32'(bus.line_err_o),     0);
    chk({pfx, "_fe"},    32'(bus.frame_err_o),    0);
    chk({pfx, "_vs"},    32'(bus.vs_cnt_o),       0);
    chk({pfx, "_hs"},    32'(bus.hs_cnt_o),       0);
  endtask

  task automatic idle_inputs();
    bus.enable = 0; bus.vsync_redge = 0; bus.hsync_redge = 0; bus.ad_in = '0;
    bus.delay_cfg = '0; bus.decim_cfg = '0; bus.spl_cfg = '0;
  endtask

  initial begin
    bit lvl;
    int r;
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");

    lvl = 1;
    for (int t = 0; t < N; t++) begin
      if (lvl && $urandom_range(0, 399) == 0) lvl = 0;
      else if (!lvl && $urandom_range(0, 59) == 0) lvl = 1;
      en_s[t]  = lvl;
      vs_s[t]  = ($urandom_range(0, 149) == 0);
      hs_s[t]  = ($urandom_range(0, 21) == 0);
      ad_s[t]  = int'($urandom_range(0, 4095));
      dly_s[t] = int'($urandom_range(0, 6));
      dec_s[t] = int'($urandom_range(0, 3));
      r        = int'($urandom_range(0, 9));
      spl_s[t] = (r < 4) ? 0 : r - 3;
    end
    build_model();

    rst = 1'b0;
    for (int t = 0; t < N; t++) begin
      bus.enable      = en_s[t];
      bus.vsync_redge = vs_s[t];
      bus.hsync_redge = hs_s[t];
      bus.ad_in       = DATA_W'(ad_s[t]);
      bus.delay_cfg   = CNT_W'(dly_s[t]);
      bus.decim_cfg   = CNT_W'(dec_s[t]);
      bus.spl_cfg     = CNT_W'(spl_s[t]);
      @(posedge clk);
      @(negedge clk);
      chk("valid",      32'(bus.sample_valid_o), 32'(e_val[t]));
      chk("data",       32'(bus.sample_data_o),  32'(e_dat[t]));
      chk("line_done",  32'(bus.line_done_o),    32'(e_ld[t]));
      chk("frame_done", 32'(bus.frame_done_o),   32'(e_fd[t]));
      chk("line_err",   32'(bus.line_err_o),     32'(e_le[t]));
      chk("frame_err",  32'(bus.frame_err_o),    32'(e_fe[t]));
      chk("vs_cnt",     32'(bus.vs_cnt_o),       32'(e_vsc[t]));
      chk("hs_cnt",     32'(bus.hs_cnt_o),       32'(e_hsc[t]));
    end

    // Directed: start a line with delay 2, reach SAMPLE, then reset mid-line.
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    bus.enable = 1; bus.vsync_redge = 1;
    @(posedge clk); @(negedge clk);
    bus.vsync_redge = 0; bus.hsync_redge = 1;
    bus.delay_cfg = 16'd2; bus.ad_in = 12'h001;
    @(posedge clk); @(negedge clk);
    bus.hsync_redge = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("dir_valid", 32'(bus.sample_valid_o), 1);
    chk("dir_data",  32'(bus.sample_data_o),  32'h800);
    chk("dir_vs",    32'(bus.vs_cnt_o),       1);
    chk("dir_hs",    32'(bus.hs_cnt_o),       1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk_zero("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
